// File: rtl/dec_arbiter.sv
// Round-robin arbiter sharing one 4-to-16 decoder among four requesters.
// Define DEC_ARBITER_CHECK_EN to enable the sticky one-hot decode check on err.
module dec_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [15:0] code,
    output logic [3:0]  gnt,
    output logic [3:0]  dec_w,
    output logic        dec_en,
    input  logic [0:15] dec_y,
    output logic [0:15] result,
    output logic        valid,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

    state_t      state_reg;
    logic [1:0]  ptr_reg;
    logic [1:0]  win_reg;
    logic [3:0]  gnt_reg;
    logic [3:0]  dec_w_reg;
    logic        dec_en_reg;
    logic        valid_reg;
    logic [0:15] result_reg;

    logic [3:0]  req_rot;
    logic [1:0]  win_offset;
    logic [1:0]  win_idx;
    logic        win_found;

    // req_rot[k] is the request of the requester k places after ptr.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign req_rot[gi] = req[ptr_reg + 2'(gi)];
        end
    endgenerate

    always_comb begin
        win_offset = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_offset = 2'(k);
            end
        end
        win_found = |req;
        win_idx   = ptr_reg + win_offset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            ptr_reg    <= 2'd0;
            win_reg    <= 2'd0;
            gnt_reg    <= 4'd0;
            dec_w_reg  <= 4'd0;
            dec_en_reg <= 1'b0;
            valid_reg  <= 1'b0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        win_reg    <= win_idx;
                        gnt_reg    <= 4'b0001 << win_idx;
                        dec_w_reg  <= code[{win_idx, 2'b00} +: 4];
                        dec_en_reg <= 1'b1;
                        state_reg  <= GRANT;
                    end
                end
                GRANT: begin
                    result_reg <= dec_y;
                    dec_en_reg <= 1'b0;
                    valid_reg  <= 1'b1;
                    state_reg  <= DONE;
                end
                DONE: begin
                    valid_reg <= 1'b0;
                    gnt_reg   <= 4'd0;
                    ptr_reg   <= win_reg + 2'd1;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign gnt    = gnt_reg;
    assign dec_w  = dec_w_reg;
    assign dec_en = dec_en_reg;
    assign result = result_reg;
    assign valid  = valid_reg;
    assign busy   = (state_reg != IDLE);

`ifdef DEC_ARBITER_CHECK_EN
    logic [0:15] onehot_ref;
    logic        err_reg;

    generate
        for (gi = 0; gi < 16; gi++) begin : g_ref
            assign onehot_ref[gi] = (dec_w_reg == 4'(gi));
        end
    endgenerate

    // Checked while result and dec_w still describe the finishing transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else if (state_reg == DONE && result_reg != onehot_ref) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dec_arbiter.sv
// Self-checking bench for dec_arbiter: directed scenarios then random traffic,
// compared every cycle against a transaction-level model.
module tb_dec_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] code;
    logic [3:0]  gnt;
    logic [3:0]  dec_w;
    logic        dec_en;
    logic [0:15] dec_y;
    logic [0:15] result;
    logic        valid;
    logic        busy;
    logic        err;
    logic        dy_force;

    int checks = 0;
    int errors = 0;

    // Model state: phase 0 = waiting, 1 = decoder cycle, 2 = result cycle.
    int          m_phase;
    int          m_ptr;
    int          m_win;
    logic [3:0]  m_code;
    logic [0:15] m_result;
    logic        m_err;

    dec_arbiter dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .code   (code),
        .gnt    (gnt),
        .dec_w  (dec_w),
        .dec_en (dec_en),
        .dec_y  (dec_y),
        .result (result),
        .valid  (valid),
        .busy   (busy),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared decoder, optionally stuck at all-ones to provoke the check.
    always_comb begin
        dec_y = '0;
        if (dy_force) dec_y = '1;
        else if (dec_en) dec_y[dec_w] = 1'b1;
    end

    function automatic logic [0:15] onehot16(input logic [3:0] k);
        logic [0:15] w;
        w = '0;
        w[k] = 1'b1;
        return w;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        if (reset) begin
            m_phase = 0; m_ptr = 0; m_win = 0; m_code = 4'd0; m_result = '0; m_err = 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    for (int j = 0; j < 4; j++) begin
                        int i;
                        i = (m_ptr + j) % 4;
                        if (req[i]) begin
                            m_win   = i;
                            m_code  = code[4*i +: 4];
                            m_phase = 1;
                            break;
                        end
                    end
                end
                1: begin
                    m_result = dy_force ? '1 : onehot16(m_code);
                    m_phase  = 2;
                end
                default: begin
`ifdef DEC_ARBITER_CHECK_EN
                    if (m_result !== onehot16(m_code)) m_err = 1'b1;
`endif
                    m_ptr   = (m_win + 1) % 4;
                    m_phase = 0;
                end
            endcase
        end
        @(posedge clk);
        #1;
        check("gnt",    {12'd0, gnt},    {12'd0, (m_phase != 0) ? 4'(1 << m_win) : 4'd0});
        check("dec_w",  {12'd0, dec_w},  {12'd0, m_code});
        check("dec_en", {15'd0, dec_en}, {15'd0, m_phase == 1});
        check("result", result,          m_result);
        check("valid",  {15'd0, valid},  {15'd0, m_phase == 2});
        check("busy",   {15'd0, busy},   {15'd0, m_phase != 0});
        check("err",    {15'd0, err},    {15'd0, m_err});
        $display("cyc req=%b gnt=%b dec_en=%b dec_w=%h valid=%b result=%h err=%b",
                 req, gnt, dec_en, dec_w, valid, result, err);
        // Served requester drops its request for the edge that ends DONE.
        if (m_phase == 2) req[m_win] = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = 4'd0; code = 16'd0; dy_force = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Single request from requester 1 with code 6.
        code[7:4] = 4'h6; req = 4'b0010;
        repeat (4) tick();

        // All four after reset, codes 0/5/A/F.
        reset = 1'b1; tick(); reset = 1'b0;
        code = 16'hFA50; req = 4'b1111;
        repeat (13) tick();

        // Wrap: ptr is back to 0, so 0 is served before 3.
        code = 16'h7002; req = 4'b1001;
        repeat (7) tick();

        // Reset in the GRANT cycle; afterwards arbitration restarts at ptr 0.
        code[7:4] = 4'h4; req = 4'b0010;
        repeat (4) tick();
        code[11:8] = 4'h8; req = 4'b0100;
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        code[3:0] = 4'h1; req = 4'b0101;
        repeat (8) tick();

        // Code change during GRANT must not affect the latched address.
        req = 4'b0000; tick();
        code[3:0] = 4'h3; req = 4'b0001;
        tick();
        code[3:0] = 4'h9;
        repeat (4) tick();

        // Decoder stuck at all-ones: err latches only when the check is built in.
        dy_force = 1'b1; code[11:8] = 4'h2; req = 4'b0100;
        repeat (4) tick();
        dy_force = 1'b0;
        repeat (3) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        tick();

        // Random traffic with occasional resets and decoder faults.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && $urandom_range(3) == 0) begin
                    code[4*i +: 4] = 4'($urandom);
                    req[i] = 1'b1;
                end
            end
            reset    = ($urandom_range(60) == 0);
            dy_force = ($urandom_range(15) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dec_arbiter.md
DEC_ARBITER -- requirements
Module: dec_arbiter

Interface
REQ-001 Parameters: none; four requesters and a 4-bit code width are fixed.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  [3:0]  request per requester, bit i = requester i; level, held until served.
REQ-005 code  input  [15:0]  requester i code at code[4i+3:4i]; stable while req[i]=1.
REQ-006 gnt  output  [3:0]  one-hot grant, high for the whole transaction of the granted requester.
REQ-007 dec_w  output  [3:0]  address driven to the shared 4-to-16 decoder.
REQ-008 dec_en  output  1  decoder enable.
REQ-009 dec_y  input  [0:15]  decoder outputs, bit k high when address k is decoded with enable.
REQ-010 result  output  [0:15]  captured decoder word for the current transaction.
REQ-011 valid  output  1  one-cycle strobe: result belongs to the requester flagged in gnt.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 err  output  1  sticky decode-check error; behaviour set under Configuration.

Function
REQ-014 FSM states: IDLE, GRANT, DONE; all outputs are registered or decoded from registered state only.
REQ-015 IDLE: if any req bit is high, select the winner round-robin starting at index ptr, ptr+1, ... (mod 4), load gnt and dec_w from that winner's code, and go to GRANT; otherwise stay in IDLE.
REQ-016 GRANT, one cycle: dec_en=1 and dec_w=latched code; result<=dec_y at the end of the cycle; next state is DONE.
REQ-017 DONE, one cycle: valid=1, dec_en=0, gnt held; ptr<=(winner+1) mod 4; next state is IDLE.
REQ-018 Latency: req sampled in IDLE at cycle N gives dec_en in N+1 and valid in N+2; maximum throughput is one transaction per 3 cycles.
REQ-019 Handshake: the requester deasserts req in the cycle after valid; a req still high in IDLE is treated as a new request.
REQ-020 req dropping or code changing during GRANT/DONE does not abort; the code latched in IDLE is used.
REQ-021 Requests arriving while busy wait; only IDLE arbitrates.
REQ-022 gnt is all-zero in IDLE; at most one gnt bit is ever set.
REQ-023 ptr wraps from 3 to 0; all four requesting at once are served in the order ptr, ptr+1, ptr+2, ptr+3.
REQ-024 result holds its value until the next GRANT cycle.

Reset
REQ-025 reset high at any edge forces: state=IDLE, ptr=0, gnt=0, dec_w=0, dec_en=0, result=0, valid=0, busy=0, err=0.
REQ-026 Reset during GRANT or DONE abandons the transaction; no valid is issued for it.

Configuration
REQ-027 Macro DEC_ARBITER_CHECK_EN defined: in DONE, err sets sticky if result is not exactly one-hot at bit index dec_w; it clears only on reset.
REQ-028 Macro undefined: the check logic is absent, err is tied to 0, and all other behaviour is identical.

Verification
REQ-029 Single request: req=4'b0010, code[7:4]=4'h6 -> dec_en at N+1 with dec_w=6; valid at N+2 with gnt=4'b0010 and result bit 6 only.
REQ-030 All four requesting after reset, codes 0/5/A/F -> grants in order 0,1,2,3; results bit 0, 5, 10, 15; valid every 3 cycles.
REQ-031 Round-robin wrap: after a grant to 3, req=4'b1001 -> requester 0 is served before 3.
REQ-032 Reset asserted in the GRANT cycle -> next cycle all outputs are 0, valid never pulses, and the next arbitration starts with ptr=0.
REQ-033 Code change during GRANT (req0 code 3 -> 9) -> result bit 3.
REQ-034 With DEC_ARBITER_CHECK_EN defined, the bench forces dec_y=16'hFFFF -> err=1 after DONE and stays 1 until reset; with the macro undefined, err stays 0.
